mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 32, data width; FAIR_LIMIT, default 4, consecutive CPU grants allowed while the loader waits; TIMEOUT, default 255, maximum wait cycles for memReady.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpuMemRead  in  1  CPU load request, level, held until cpuDone.
- cpuMemWrite  in  1  CPU store request, level, held until cpuDone.
- cpuAddr  in  ADDR_W  CPU address.
- cpuWData  in  DATA_W  CPU store data.
- cpuStall  out  1  freezes the PC/pipeline.
- cpuDone  out  1  one-cycle CPU completion pulse.
- cpuRData  out  DATA_W  CPU load data, valid with cpuDone.
- ldrReq  in  1  weight-loader request, level, held until ldrDone.
- ldrWrite  in  1  loader direction: 1 write, 0 read.
- ldrAddr  in  ADDR_W  loader address.
- ldrWData  in  DATA_W  loader write data.
- ldrDone  out  1  one-cycle loader completion pulse.
- ldrRData  out  DATA_W  loader read data, valid with ldrDone.
- memEn  out  1  memory access strobe.
- memWe  out  1  memory write enable.
- memAddr  out  ADDR_W  memory address.
- memWData  out  DATA_W  memory write data.
- memRData  in  DATA_W  memory read data, valid with memReady.
- memReady  in  1  memory completion.
- errFlag  out  1  sticky error.

Function
REQ-003 The FSM SHALL have four states: IDLE, CPU_ACC, LDR_ACC, DONE.
REQ-004 In IDLE, the arbiter SHALL grant only if a request is present.
- Loader wins if ldrReq=1 and (no CPU request or streak==FAIR_LIMIT).
- Otherwise the CPU wins if cpuMemRead|cpuMemWrite.
REQ-005 On a grant, the arbiter SHALL register the winner's address, write data and direction into memAddr, memWData and memWe. It SHALL enter CPU_ACC or LDR_ACC on the next edge.
REQ-006 In CPU_ACC and LDR_ACC, memEn SHALL be 1 and memAddr, memWe and memWData SHALL be held stable.
REQ-007 In any access state, memReady=1 SHALL cause a transition to DONE.
- Reads: memRData is captured into cpuRData or ldrRData.
- The cycle in which memReady is sampled is the last cycle with memEn=1.
REQ-008 In DONE, the owner's done pulse SHALL be 1 for exactly one cycle, memEn SHALL be 0, and the next state SHALL be IDLE unconditionally. This means the still-held old request is never re-granted.
REQ-009 Minimum latency SHALL be: request sampled in IDLE at cycle N, memEn high at N+1, memReady at N+1, done at N+2.
REQ-010 cpuStall SHALL be combinational: (cpuMemRead|cpuMemWrite) & ~cpuDone.
REQ-011 The 3-bit streak counter SHALL:
- increment on a CPU grant made while ldrReq=1;
- clear on a loader grant;
- clear in IDLE when ldrReq=0;
- saturate at FAIR_LIMIT.
REQ-012 If cpuMemRead and cpuMemWrite are both 1 at grant, the access SHALL be treated as a write and errFlag SHALL be set.
REQ-013 A watchdog SHALL count cycles spent in an access state. When the count reaches TIMEOUT without memReady:
- the next state is DONE;
- errFlag is set;
- read data returns all-ones.
REQ-014 errFlag SHALL clear only on reset.
REQ-015 The arbiter SHALL ignore memReady outside the access states.

Reset
REQ-016 When reset=1 at a clock edge, the following SHALL hold at the next cycle:
- state is IDLE;
- streak and watchdog are 0;
- memEn, memWe, cpuDone, ldrDone and errFlag are 0;
- memAddr, memWData, cpuRData and ldrRData are 0.
REQ-017 Reset during an access SHALL abort the access with no done pulse. The requester SHALL re-present its request after reset.
REQ-018 cpuStall SHALL follow REQ-010 during reset.

Verification
REQ-019 CPU load: cpuMemRead=1, cpuAddr=0x0010, memReady one cycle after memEn, memRData=0xDEADBEEF -> memEn for 1 cycle, cpuDone at N+2, cpuRData=0xDEADBEEF, cpuStall low only in the cpuDone cycle.
REQ-020 Loader write with a 3-cycle memory: ldrReq=1, ldrWrite=1, ldrAddr=0x0200, ldrWData=0x12345678 -> memWe=1 and memEn=1 for 3 cycles with stable address and data, then a single ldrDone.
REQ-021 Fairness: CPU requests back-to-back while ldrReq is held -> exactly 4 CPU grants, then a loader grant, then the CPU again; ldrDone arrives within 5 accesses.
REQ-022 Timeout: CPU read with memReady never asserted -> after 255 access cycles, cpuDone=1, cpuRData=0xFFFFFFFF, errFlag=1 and sticky.
REQ-023 Reset mid-access: reset during LDR_ACC -> next cycle memEn=0, no ldrDone, state IDLE; the loader request is then re-granted normally.
REQ-024 Simultaneous read and write from the CPU -> a write is performed and errFlag=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its CPU, weight-loader and memory neighbours.
// The arbiter uses the slave view; the surrounding system (or bench) uses the master view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();

  // CPU port
  logic              cpuMemRead;
  logic              cpuMemWrite;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWData;
  logic              cpuStall;
  logic              cpuDone;
  logic [DATA_W-1:0] cpuRData;

  // Weight-loader port
  logic              ldrReq;
  logic              ldrWrite;
  logic [ADDR_W-1:0] ldrAddr;
  logic [DATA_W-1:0] ldrWData;
  logic              ldrDone;
  logic [DATA_W-1:0] ldrRData;

  // Memory port
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memReady;

  logic              errFlag;

  modport slave (
    input  cpuMemRead, cpuMemWrite, cpuAddr, cpuWData,
    output cpuStall, cpuDone, cpuRData,
    input  ldrReq, ldrWrite, ldrAddr, ldrWData,
    output ldrDone, ldrRData,
    output memEn, memWe, memAddr, memWData,
    input  memRData, memReady,
    output errFlag
  );

  modport master (
    output cpuMemRead, cpuMemWrite, cpuAddr, cpuWData,
    input  cpuStall, cpuDone, cpuRData,
    output ldrReq, ldrWrite, ldrAddr, ldrWData,
    input  ldrDone, ldrRData,
    input  memEn, memWe, memAddr, memWData,
    output memRData, memReady,
    input  errFlag
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a CPU and a weight loader, with a CPU-streak
// fairness limit, a memReady watchdog and a sticky error flag.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FAIR_LIMIT = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCpuAcc, StLdrAcc, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]        streak_q, streak_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              owner_q, owner_d;  // 1: loader owns the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              err_q, err_d;

  logic cpu_req, cpu_win, ldr_win, in_acc, timeout, acc_end, grant;
  logic cpu_done, ldr_done;
  logic [DATA_W-1:0] rdata_cap;

  assign cpu_req = bus.cpuMemRead | bus.cpuMemWrite;
  assign ldr_win = bus.ldrReq & (~cpu_req | (streak_q == 3'(FAIR_LIMIT)));
  assign cpu_win = cpu_req & ~ldr_win;
  assign grant   = (state_q == StIdle) & (ldr_win | cpu_win);
  assign in_acc  = (state_q == StCpuAcc) | (state_q == StLdrAcc);
  assign timeout = in_acc & ~bus.memReady & (wdog_q == WdogW'(TIMEOUT - 1));
  assign acc_end = in_acc & (bus.memReady | timeout);
  // A timed-out read returns all-ones so the requester sees obviously bad data.
  assign rdata_cap = bus.memReady ? bus.memRData : '1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ldr_win) begin
          state_d = StLdrAcc;
        end else if (cpu_win) begin
          state_d = StCpuAcc;
        end
      end
      StCpuAcc, StLdrAcc: begin
        if (acc_end) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    cpu_done     = (state_q == StDone) & ~owner_q;
    ldr_done     = (state_q == StDone) & owner_q;
    bus.cpuDone  = cpu_done;
    bus.ldrDone  = ldr_done;
    bus.cpuStall = cpu_req & ~cpu_done;
    bus.memEn    = in_acc;
    bus.memWe    = we_q;
    bus.memAddr  = addr_q;
    bus.memWData = wdata_q;
    bus.cpuRData = cpu_rdata_q;
    bus.ldrRData = ldr_rdata_q;
    bus.errFlag  = err_q;
  end

  // Datapath next-state: grant capture, fairness streak, watchdog, read capture
  always_comb begin
    streak_d    = streak_q;
    wdog_d      = '0;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    err_d       = err_q;

    if (state_q == StIdle) begin
      if (ldr_win) begin
        streak_d = '0;
      end else if (cpu_win && bus.ldrReq) begin
        if (streak_q < 3'(FAIR_LIMIT)) begin
          streak_d = streak_q + 3'd1;
        end
      end else if (!bus.ldrReq) begin
        streak_d = '0;
      end
    end

    if (grant) begin
      owner_d = ldr_win;
      addr_d  = ldr_win ? bus.ldrAddr  : bus.cpuAddr;
      wdata_d = ldr_win ? bus.ldrWData : bus.cpuWData;
      // A CPU read+write collision is resolved as a write and flagged.
      we_d    = ldr_win ? bus.ldrWrite : bus.cpuMemWrite;
      if (cpu_win && bus.cpuMemRead && bus.cpuMemWrite) begin
        err_d = 1'b1;
      end
    end

    if (in_acc && !acc_end) begin
      wdog_d = wdog_q + WdogW'(1);
    end

    if (acc_end && !we_q) begin
      if (owner_q) begin
        ldr_rdata_d = rdata_cap;
      end else begin
        cpu_rdata_d = rdata_cap;
      end
    end

    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q    <= '0;
      wdog_q      <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU load, slow loader write, fairness, timeout,
// reset mid-access and CPU read/write collision.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk;
  logic reset;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FAIR_LIMIT(4),
    .TIMEOUT   (255)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model: memReady after mem_lat cycles of memEn (0 = never ready)
  int          mem_lat  = 1;
  logic [31:0] mem_data = '0;
  int          lat_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.memEn) begin
      bus.memReady = (mem_lat != 0) && (lat_cnt == mem_lat - 1);
      bus.memRData = mem_data;
      lat_cnt      = lat_cnt + 1;
    end else begin
      bus.memReady = 1'b0;
      bus.memRData = '0;
      lat_cnt      = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input bit is_ldr, input int limit,
                           output int en_cycles);
    bit got;
    en_cycles = 0;
    got       = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (bus.memEn) en_cycles++;
      if (is_ldr ? bus.ldrDone : bus.cpuDone) got = 1'b1;
    end
    check(tag, 64'(got), 64'd1);
  endtask

  initial begin
    int    en;
    byte   ev[$];
    string exp_seq;

    exp_seq         = "CCCCLC";
    reset           = 1'b1;
    bus.cpuMemRead  = 1'b0;
    bus.cpuMemWrite = 1'b0;
    bus.cpuAddr     = '0;
    bus.cpuWData    = '0;
    bus.ldrReq      = 1'b0;
    bus.ldrWrite    = 1'b0;
    bus.ldrAddr     = '0;
    bus.ldrWData    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_memEn", 64'(bus.memEn), 64'd0);
    check("rst_memWe", 64'(bus.memWe), 64'd0);
    check("rst_dones", 64'({bus.cpuDone, bus.ldrDone}), 64'd0);
    check("rst_err", 64'(bus.errFlag), 64'd0);
    check("rst_addr", 64'(bus.memAddr), 64'd0);
    check("rst_wdata", 64'(bus.memWData), 64'd0);
    check("rst_rdata", 64'({bus.cpuRData, bus.ldrRData}), 64'd0);
    bus.cpuMemRead = 1'b1;
    #1 check("rst_stall", 64'(bus.cpuStall), 64'd1);
    bus.cpuMemRead = 1'b0;
    #1 check("rst_stall_lo", 64'(bus.cpuStall), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // CPU load, single-cycle memory
    mem_lat        = 1;
    mem_data       = 32'hDEADBEEF;
    bus.cpuMemRead = 1'b1;
    bus.cpuAddr    = 16'h0010;
    #1 check("ld_stall_req", 64'(bus.cpuStall), 64'd1);
    @(negedge clk);
    check("ld_memEn", 64'(bus.memEn), 64'd1);
    check("ld_addr", 64'(bus.memAddr), 64'h10);
    check("ld_we", 64'(bus.memWe), 64'd0);
    check("ld_stall_acc", 64'(bus.cpuStall), 64'd1);
    check("ld_nodone", 64'(bus.cpuDone), 64'd0);
    @(negedge clk);
    check("ld_done", 64'(bus.cpuDone), 64'd1);
    check("ld_rdata", 64'(bus.cpuRData), 64'hDEADBEEF);
    check("ld_memEn_off", 64'(bus.memEn), 64'd0);
    check("ld_stall_done", 64'(bus.cpuStall), 64'd0);
    bus.cpuMemRead = 1'b0;
    @(negedge clk);
    check("ld_done_pulse", 64'(bus.cpuDone), 64'd0);

    // Loader write, 3-cycle memory
    mem_lat      = 3;
    bus.ldrReq   = 1'b1;
    bus.ldrWrite = 1'b1;
    bus.ldrAddr  = 16'h0200;
    bus.ldrWData = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("lw_cyc%0d", i),
            64'({bus.memEn, bus.memWe, bus.ldrDone, bus.memAddr, bus.memWData}),
            64'({1'b1, 1'b1, 1'b0, 16'h0200, 32'h12345678}));
    end
    @(negedge clk);
    check("lw_done", 64'({bus.ldrDone, bus.memEn}), 64'b10);
    bus.ldrReq   = 1'b0;
    bus.ldrWrite = 1'b0;
    @(negedge clk);
    check("lw_done_pulse", 64'(bus.ldrDone), 64'd0);

    // Fairness: CPU back-to-back while the loader waits
    mem_lat        = 1;
    mem_data       = 32'h0BADF00D;
    bus.ldrReq     = 1'b1;
    bus.ldrAddr    = 16'h0400;
    bus.cpuMemRead = 1'b1;
    bus.cpuAddr    = 16'h0020;
    for (int i = 0; i < 60 && ev.size() < 6; i++) begin
      @(negedge clk);
      if (bus.cpuDone) ev.push_back("C");
      if (bus.ldrDone) begin
        ev.push_back("L");
        check("fair_ldr_rdata", 64'(bus.ldrRData), 64'h0BADF00D);
        bus.ldrReq = 1'b0;
      end
    end
    bus.cpuMemRead = 1'b0;
    bus.ldrReq     = 1'b0;
    check("fair_count", 64'(ev.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fair_ev%0d", i), 64'((i < ev.size()) ? ev[i] : 8'd0),
            64'(exp_seq[i]));
    end
    @(negedge clk);

    // Timeout: memory never answers
    mem_lat        = 0;
    bus.cpuMemRead = 1'b1;
    bus.cpuAddr    = 16'h0044;
    check("to_err_before", 64'(bus.errFlag), 64'd0);
    wait_done("to_done", 1'b0, 400, en);
    check("to_en_cycles", 64'(en), 64'd255);
    check("to_rdata", 64'(bus.cpuRData), 64'hFFFFFFFF);
    check("to_err", 64'(bus.errFlag), 64'd1);
    bus.cpuMemRead = 1'b0;
    repeat (3) @(negedge clk);
    check("to_err_sticky", 64'(bus.errFlag), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("to_err_cleared", 64'(bus.errFlag), 64'd0);

    // Reset during a loader access
    bus.ldrReq   = 1'b1;
    bus.ldrWrite = 1'b0;
    bus.ldrAddr  = 16'h0300;
    @(negedge clk);
    check("rm_memEn", 64'(bus.memEn), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rm_abort", 64'({bus.memEn, bus.ldrDone, bus.memAddr}), 64'd0);
    mem_lat  = 1;
    mem_data = 32'hCAFEF00D;
    reset    = 1'b0;
    wait_done("rm_regrant", 1'b1, 10, en);
    check("rm_en_cycles", 64'(en), 64'd1);
    check("rm_rdata", 64'(bus.ldrRData), 64'hCAFEF00D);
    bus.ldrReq = 1'b0;
    @(negedge clk);

    // CPU read and write together: performed as a write, error flagged
    bus.cpuMemRead  = 1'b1;
    bus.cpuMemWrite = 1'b1;
    bus.cpuAddr     = 16'h0055;
    bus.cpuWData    = 32'hA5A5A5A5;
    @(negedge clk);
    check("rw_access", 64'({bus.memEn, bus.memWe, bus.memAddr, bus.memWData}),
          64'({1'b1, 1'b1, 16'h0055, 32'hA5A5A5A5}));
    check("rw_err", 64'(bus.errFlag), 64'd1);
    wait_done("rw_done", 1'b0, 10, en);
    bus.cpuMemRead  = 1'b0;
    bus.cpuMemWrite = 1'b0;
    @(negedge clk);
    check("rw_err_sticky", 64'(bus.errFlag), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
